// File: rtl/bcast_tree_rr_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcast_tree_rr_scheduler_pkg
// Description : Shared definitions for the broadcast-tree round-robin
//               scheduler: FSM state encoding and the helper functions that
//               derive the source-ID width and the tree pipeline latency.
// Revision    : 1.0 - initial release
// ============================================================================
package bcast_tree_rr_scheduler_pkg;

   localparam logic [1:0] c_ST_IDLE   = 2'd0;
   localparam logic [1:0] c_ST_ACTIVE = 2'd1;
   localparam logic [1:0] c_ST_DRAIN  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE   = c_ST_IDLE,
      ST_ACTIVE = c_ST_ACTIVE,
      ST_DRAIN  = c_ST_DRAIN
   } state_e;

   // Width of a requester index; never narrower than one bit.
   function automatic int calc_id_w(input int num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

   // One register stage per tree level plus the input register of the tree.
   function automatic int calc_latency(input int num_output_data);
      return $clog2(num_output_data) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcast_tree_rr_scheduler_rr_arbiter_onehot.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_onehot
// Description : Purely combinational round-robin arbiter. Picks the first
//               asserted request at or after the pointer, scanning modulo
//               NUM_REQ, and returns it as a one-hot grant plus an index.
// Ports       : i_req   - request vector
//               i_ptr   - index with highest priority this cycle
//               i_en    - when low, no grant is produced
//               o_grant - one-hot grant (all zero if none)
//               o_idx   - index of the granted requester (0 if none)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_onehot
   import bcast_tree_rr_scheduler_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = calc_id_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [ID_W-1:0]    i_ptr,
   input  logic               i_en,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [ID_W-1:0]    o_idx
);

   logic            w_found;
   logic [ID_W-1:0] w_j;
   int              w_j_int;

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_j     = '0;
      w_j_int = 0;
      for (int off = 0; off < NUM_REQ; off++) begin
         // Pointer is always < NUM_REQ, so one subtraction wraps the scan.
         w_j_int = int'(i_ptr) + off;
         if (w_j_int >= NUM_REQ) begin
            w_j_int = w_j_int - NUM_REQ;
         end
         w_j = ID_W'(w_j_int);
         if (i_en && !w_found && i_req[w_j]) begin
            w_found      = 1'b1;
            o_grant[w_j] = 1'b1;
            o_idx        = w_j;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/bcast_tree_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : bcast_tree_rr_scheduler
// Description : Shares one pipelined 1-to-NUM_OUTPUT_DATA broadcast tree among
//               NUM_REQ requesters with round-robin arbitration. Drives the
//               tree valid/data/enable, holds the enable only while traffic
//               is pending or in flight, and delays the winner ID so it lines
//               up with the tree's registered outputs.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_req_valid   - per-requester valid
//               i_req_data    - requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//               o_req_ready   - one-hot grant/ready
//               i_flush       - pulse; aborts every in-flight word
//               o_tree_valid  - tree valid input
//               o_tree_data   - tree data input
//               o_tree_en     - tree enable (registered)
//               o_src_valid   - tree outputs carry a valid word this cycle
//               o_src_id      - requester index of that word
//               o_busy        - not idle or words still in flight
//               o_issue_cnt   - wrapping count of issued words
// Revision    : 1.0 - initial release
// ============================================================================
module bcast_tree_rr_scheduler
   import bcast_tree_rr_scheduler_pkg::*;
#(
   parameter  int DATA_WIDTH      = 32,
   parameter  int NUM_REQ         = 4,
   parameter  int NUM_OUTPUT_DATA = 8,
   parameter  int IDLE_CYCLES     = 4,
   localparam int ID_W            = calc_id_w(NUM_REQ),
   localparam int LATENCY         = calc_latency(NUM_OUTPUT_DATA)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            i_req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
   output logic [NUM_REQ-1:0]            o_req_ready,
   input  logic                          i_flush,
   output logic                          o_tree_valid,
   output logic [DATA_WIDTH-1:0]         o_tree_data,
   output logic                          o_tree_en,
   output logic                          o_src_valid,
   output logic [ID_W-1:0]               o_src_id,
   output logic                          o_busy,
   output logic [15:0]                   o_issue_cnt
);

   localparam int              IDLE_W      = $clog2(IDLE_CYCLES + 1);
   localparam logic [IDLE_W-1:0] c_IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
   localparam logic [ID_W-1:0]   c_PTR_LAST  = ID_W'(NUM_REQ - 1);

   state_e              r_state;
   state_e              w_state_nxt;
   logic                r_tree_en;
   logic [ID_W-1:0]     r_ptr;
   logic [IDLE_W-1:0]   r_idle_cnt;
   logic [IDLE_W-1:0]   w_idle_nxt;
   logic [15:0]         r_issue_cnt;
   logic [LATENCY-1:0]  r_sr_vld;
   logic [ID_W-1:0]     r_sr_id [LATENCY];

   logic                w_arb_en;
   logic [NUM_REQ-1:0]  w_grant;
   logic [ID_W-1:0]     w_win;
   logic                w_hs;
   logic                w_any_req;
   logic                w_inflight;
   logic [ID_W-1:0]     w_ptr_inc;
   logic [DATA_WIDTH-1:0] w_win_data;

   // Flush and reset both suppress the grant in the same cycle.
   assign w_arb_en   = (r_state == ST_ACTIVE) && !i_flush && !rst;
   assign w_any_req  = |i_req_valid;
   assign w_inflight = |r_sr_vld;
   // A grant is only ever given to an asserted valid, so any grant is a handshake.
   assign w_hs       = |w_grant;
   assign w_ptr_inc  = (w_win == c_PTR_LAST) ? '0 : w_win + ID_W'(1);

   rr_arbiter_onehot #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .i_req   (i_req_valid),
      .i_ptr   (r_ptr),
      .i_en    (w_arb_en),
      .o_grant (w_grant),
      .o_idx   (w_win)
   );

   // AND-OR mux on the one-hot grant; yields zero when nothing is granted.
   always_comb begin
      w_win_data = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (w_grant[k]) begin
            w_win_data = w_win_data | i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idle_nxt  = r_idle_cnt;
      if (i_flush) begin
         w_state_nxt = ST_IDLE;
         w_idle_nxt  = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_idle_nxt = '0;
               if (w_any_req) begin
                  w_state_nxt = ST_ACTIVE;
               end
            end
            ST_ACTIVE: begin
               if (w_any_req) begin
                  w_idle_nxt = '0;
               end else if (r_idle_cnt == c_IDLE_LAST) begin
                  w_state_nxt = ST_DRAIN;
                  w_idle_nxt  = '0;
               end else begin
                  w_idle_nxt = r_idle_cnt + IDLE_W'(1);
               end
            end
            ST_DRAIN: begin
               w_idle_nxt = '0;
               // A new request wins over draining to IDLE. The enable must
               // stay up until the tree has emptied, or words get zeroed.
               if (w_any_req) begin
                  w_state_nxt = ST_ACTIVE;
               end else if (!w_inflight) begin
                  w_state_nxt = ST_IDLE;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_idle_nxt  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_tree_en   <= 1'b0;
         r_ptr       <= '0;
         r_idle_cnt  <= '0;
         r_issue_cnt <= '0;
         r_sr_vld    <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            r_sr_id[i] <= '0;
         end
      end else begin
         r_state    <= w_state_nxt;
         r_tree_en  <= (w_state_nxt != ST_IDLE);
         r_idle_cnt <= w_idle_nxt;
         if (w_hs) begin
            r_ptr       <= w_ptr_inc;
            r_issue_cnt <= r_issue_cnt + 16'd1;
         end
         if (i_flush) begin
            r_sr_vld <= '0;
            for (int i = 0; i < LATENCY; i++) begin
               r_sr_id[i] <= '0;
            end
         end else begin
            for (int i = LATENCY - 1; i > 0; i--) begin
               r_sr_vld[i] <= r_sr_vld[i-1];
               r_sr_id[i]  <= r_sr_id[i-1];
            end
            r_sr_vld[0] <= w_hs;
            // Storing zero for empty slots keeps o_src_id at 0 when invalid.
            r_sr_id[0]  <= w_hs ? w_win : '0;
         end
      end
   end

   // Every output reads zero while reset is held, even mid-transfer.
   assign o_req_ready  = w_grant;
   assign o_tree_valid = w_hs;
   assign o_tree_data  = w_win_data;
   assign o_tree_en    = r_tree_en & ~rst;
   assign o_src_valid  = r_sr_vld[LATENCY-1] & ~rst;
   assign o_src_id     = rst ? '0 : r_sr_id[LATENCY-1];
   assign o_busy       = ~rst & ((r_state != ST_IDLE) | w_inflight);
   assign o_issue_cnt  = rst ? '0 : r_issue_cnt;

endmodule
`default_nettype wire

// File: doc/bcast_tree_rr_scheduler.md
Name: bcast_tree_rr_scheduler

Overview:
- Shares one pipelined 1-to-NUM_OUTPUT_DATA broadcast wire tree among NUM_REQ requesters using round-robin arbitration with a valid/ready handshake.
- Drives the tree's valid, data and enable inputs, and raises the enable only while traffic is pending or in flight.
- Delays each winner's source ID to line up with the tree's registered outputs, so consumers know who broadcast each word.
- Sits between requester FIFOs and the broadcast tree in the crossbar.

Parameters:
- DATA_WIDTH, 32, width of one data word.
- NUM_REQ, 4, number of requesters (>=2).
- NUM_OUTPUT_DATA, 8, fan-out of the driven tree (power of 2).
- IDLE_CYCLES, 4, consecutive empty cycles in ACTIVE before the enable is dropped (>=1).
- Derived: ID_W = max(1, $clog2(NUM_REQ)); LATENCY = $clog2(NUM_OUTPUT_DATA)+1, which is 4 at default.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- i_req_valid  in  NUM_REQ  per-requester valid.
- i_req_data  in  NUM_REQ*DATA_WIDTH  requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- o_req_ready  out  NUM_REQ  one-hot grant/ready.
- i_flush  in  1  single-cycle pulse; abort all in-flight words.
- o_tree_valid  out  1  to tree valid input.
- o_tree_data  out  DATA_WIDTH  to tree data input.
- o_tree_en  out  1  to tree enable (registered).
- o_src_valid  out  1  high in the cycle the tree's outputs carry a valid word.
- o_src_id  out  ID_W  requester index of that word.
- o_busy  out  1  state!=IDLE or any word in flight.
- o_issue_cnt  out  16  count of words issued; wraps.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state=IDLE, o_tree_en=0, RR pointer=0, in-flight and ID shift registers cleared, o_issue_cnt=0. All outputs are 0 during reset, including mid-transfer; in-flight words are discarded.
- States: IDLE, ACTIVE, DRAIN. o_tree_en=1 in ACTIVE and DRAIN.
- IDLE:
  - o_req_ready=0.
  - Any i_req_valid bit set → ACTIVE next cycle. Wake latency is 1 cycle, because the tree needs its enable before it can latch.
- ACTIVE:
  - Winner = first valid index at or after the pointer, scanning modulo NUM_REQ.
  - o_req_ready = onehot(winner); o_tree_valid=1; o_tree_data = winner's data.
  - Handshake happens when valid&ready. On a handshake: pointer ← winner+1 (mod NUM_REQ), o_issue_cnt+1.
  - With no valid requests: o_tree_valid=0, o_tree_data=0, and the idle counter increments. Any request clears it.
  - Idle counter reaching IDLE_CYCLES → DRAIN.
- DRAIN:
  - o_req_ready=0.
  - Any new request → ACTIVE.
  - Else, in-flight register all-zero → IDLE.
  - The enable is never dropped while a word is in flight, because the tree zeroes its contents when disabled.
- Alignment:
  - A LATENCY-deep shift register carries {valid, id} for each issued word.
  - A word issued at edge t appears on o_src_valid/o_src_id in cycle t+LATENCY, the same cycle as the tree output.
  - o_src_id=0 when o_src_valid=0.
- Flush:
  - On i_flush: o_req_ready=0 and o_tree_en=0 for the next cycle, which clears the tree.
  - Shift registers are cleared and state → IDLE. The pointer and counter are kept.
  - Flush overrides a same-cycle handshake: no grant is issued.
- Simultaneous events: rst > i_flush > arbitration. A request arriving while DRAIN completes goes to ACTIVE, not IDLE.
- Throughput: 1 word per cycle in ACTIVE with no bubbles between different requesters.
- o_issue_cnt wraps 0xFFFF → 0.

Decomposition:
- Shared package: ID_W and LATENCY derivation functions, state encoding localparams (IDLE=0, ACTIVE=1, DRAIN=2).
- One sub-module, rr_arbiter_onehot (params NUM_REQ):
  - inputs: req vector, pointer, enable;
  - outputs: one-hot grant, winner index;
  - purely combinational.
- The FSM, shift registers and counters stay in the top module.

Test Plan:
- Reset, then i_req_valid=4'b0001 with data 0xA5 at cycle 0 → o_tree_en=1 at cycle 1; ready[0] and handshake at cycle 1; o_src_valid=1 with o_src_id=0 at cycle 5; o_issue_cnt=1.
- All four requesters held valid for 8 cycles in ACTIVE → grant order 0,1,2,3,0,1,2,3; o_src_id repeats that order 4 cycles later; no bubbles.
- Single burst, then silence → DRAIN entered IDLE_CYCLES(4) cycles after the last issue; IDLE (o_tree_en=0) only after o_src_valid has fallen; o_busy falls on the same cycle.
- i_flush one cycle after issuing IDs 2 and 3 → o_tree_en=0 next cycle; o_src_valid never asserts for those words; state IDLE; pointer preserved (next grant from index 0 if 2 and 3 were the last winners).
- rst asserted mid-burst with 3 words in flight → all outputs 0 the next cycle; no o_src_valid afterwards; o_issue_cnt=0.
- Force o_issue_cnt to 0xFFFF, issue one word → count reads 0x0000.
